// File: rtl/add_sub_seq_pkg.sv
// Shared types and helpers for the chunked sequential adder/subtractor.
// Holds the FSM states, the mode encoding and the chunk-count/counter-width math.
package add_sub_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    function automatic int calc_k(input int width, input int chunk);
        return width / chunk;
    endfunction

    // A single-chunk datapath still needs a 1-bit counter.
    function automatic int calc_cnt_w(input int width, input int chunk);
        int k;
        k = width / chunk;
        return (k <= 1) ? 1 : $clog2(k);
    endfunction

endpackage

// File: rtl/add_sub_seq_if.sv
// Request/result bundle between a requester and the add_sub_seq engine.
interface add_sub_seq_if #(
    parameter int WIDTH = 8
);
    logic             i_start;
    logic             i_m;
    logic             i_acc;
    logic             i_clr;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             o_busy;
    logic             o_done;
    logic [WIDTH-1:0] o_s;
    logic             o_c;
    logic             o_v;
    logic             o_z;
    logic             o_n;

    modport master (
        output i_start, i_m, i_acc, i_clr, i_a, i_b,
        input  o_busy, o_done, o_s, o_c, o_v, o_z, o_n
    );

    modport slave (
        input  i_start, i_m, i_acc, i_clr, i_a, i_b,
        output o_busy, o_done, o_s, o_c, o_v, o_z, o_n
    );
endinterface

// File: rtl/add_sub_seq_chunk_adder.sv
// CHUNK-bit ripple-carry adder; also exposes the carry into its top bit
// so the caller can form the signed-overflow flag on the last chunk.
module chunk_adder #(
    parameter int CHUNK = 2
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb_in
);
    logic [CHUNK:0] w_c;

    assign w_c[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign sum[i]   = x[i] ^ y[i] ^ w_c[i];
        assign w_c[i+1] = (x[i] & y[i]) | (w_c[i] & (x[i] ^ y[i]));
    end

    assign cout     = w_c[CHUNK];
    assign c_msb_in = w_c[CHUNK-1];
endmodule

// File: rtl/add_sub_seq.sv
// Sequential two's-complement add/subtract engine: CHUNK bits per cycle,
// LS chunk first, with S doubling as an accumulator operand.
module add_sub_seq
    import add_sub_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input logic          clk,
    input logic          rst_n,
    add_sub_seq_if.slave bus
);
    localparam int K     = calc_k(WIDTH, CHUNK);
    localparam int CNT_W = calc_cnt_w(WIDTH, CHUNK);

    if (WIDTH < 2 || (WIDTH % CHUNK) != 0) begin : g_bad_param
        $error("add_sub_seq: WIDTH must be >= 2 and a multiple of CHUNK");
    end

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_opa;
    logic [WIDTH-1:0]   r_opb;
    logic [WIDTH-1:0]   r_res;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_s;
    logic               r_c;
    logic               r_v;
    logic               r_z;
    logic               r_n;

    logic [CHUNK-1:0]       w_sum;
    logic                   w_cout;
    logic                   w_cmsb;
    logic [WIDTH+CHUNK-1:0] w_cat;
    logic [WIDTH-1:0]       w_res_nxt;
    logic                   w_last;
    logic                   w_sub;

    chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
        .x        (r_opa[CHUNK-1:0]),
        .y        (r_opb[CHUNK-1:0]),
        .cin      (r_carry),
        .sum      (w_sum),
        .cout     (w_cout),
        .c_msb_in (w_cmsb)
    );

    // New chunk enters at the top; after K shifts the LS chunk sits at bit 0.
    assign w_cat     = {w_sum, r_res};
    assign w_res_nxt = w_cat[WIDTH+CHUNK-1:CHUNK];
    assign w_last    = (r_cnt == CNT_W'(K - 1));
    assign w_sub     = (bus.i_m == MODE_SUB);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (!bus.i_clr && bus.i_start) w_state_nxt = RUN;
            RUN:     if (w_last) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_opa   <= '0;
            r_opb   <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_s     <= '0;
            r_c     <= 1'b0;
            r_v     <= 1'b0;
            r_z     <= 1'b0;
            r_n     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    if (bus.i_clr) begin
                        r_s <= '0;
                        r_c <= 1'b0;
                        r_v <= 1'b0;
                        r_z <= 1'b0;
                        r_n <= 1'b0;
                    end else if (bus.i_start) begin
                        r_opa   <= bus.i_acc ? r_s : bus.i_a;
                        r_opb   <= bus.i_b ^ {WIDTH{w_sub}};
                        r_carry <= w_sub;
                        r_cnt   <= '0;
                    end
                end
                RUN: begin
                    r_opa   <= r_opa >> CHUNK;
                    r_opb   <= r_opb >> CHUNK;
                    r_res   <= w_res_nxt;
                    r_carry <= w_cout;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_s <= w_res_nxt;
                        r_c <= w_cout;
                        r_v <= w_cout ^ w_cmsb;
                        r_z <= (w_res_nxt == '0);
                        r_n <= w_res_nxt[WIDTH-1];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.o_busy = (r_state != IDLE);
    assign bus.o_done = (r_state == DONE);
    assign bus.o_s    = r_s;
    assign bus.o_c    = r_c;
    assign bus.o_v    = r_v;
    assign bus.o_z    = r_z;
    assign bus.o_n    = r_n;
endmodule

// File: doc/add_sub_seq.md
# add_sub_seq

Parametrised multi-cycle two's-complement adder/subtractor with an internal accumulator. It processes operands CHUNK bits per clock, least-significant chunk first, through a carry register. It reports sum, carry, overflow, zero and negative flags under a start/busy/done handshake. It is the sequential, width-generic successor to the team's 4-bit combinational adder-subtractor and serves as the arithmetic engine for wider datapaths where area matters more than latency.

## Interface
- WIDTH, 8, operand and result width in bits; must be ≥ 2.
- CHUNK, 2, bits processed per RUN cycle; WIDTH % CHUNK == 0 is required. K = WIDTH/CHUNK.
- CLK  in  1  single clock; all state changes on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- START  in  1  request; sampled only in IDLE.
- M  in  1  0 = add, 1 = subtract (second operand inverted, carry-in = 1).
- ACC  in  1  1 = first operand is the accumulator (current S), not A.
- CLR  in  1  synchronous clear of S and all flags; honoured only in IDLE.
- A  in  WIDTH  first operand.
- B  in  WIDTH  second operand.
- BUSY  out  1  high in RUN and DONE states.
- DONE  out  1  one-cycle pulse; results valid and updated.
- S  out  WIDTH  result register; also the accumulator.
- C  out  1  carry out of MSB. For subtract, 1 = no borrow.
- V  out  1  signed overflow: carry into MSB XOR carry out of MSB.
- Z  out  1  S == 0.
- N  out  1  S[WIDTH-1].

## Operation
- States are IDLE, RUN and DONE.
- **IDLE:**
  - CLR=1 clears S, C, V, Z and N to 0. If START is also 1, the START is dropped.
  - Otherwise, START=1 does the following at that edge:
    - latches the first operand (ACC ? S : A);
    - latches the second operand as B XOR {WIDTH{M}};
    - loads the carry register with M;
    - clears the chunk counter;
    - moves to RUN.
- **RUN:**
  - Each edge adds chunk i of both operands plus the carry register.
  - The CHUNK-bit sum is shifted into the internal result register, and the carry register is updated.
  - On the K-th RUN edge, the block writes S, C, V, Z and N together, then enters DONE. V uses the carry into MSB from the final chunk.
- **DONE:** DONE=1 for exactly one cycle, then the block returns to IDLE unconditionally.
- START, CLR, M, ACC, A and B are ignored whenever BUSY=1. They need to be valid only at the accepting edge.
- S and the flags change only at the final RUN edge, on CLR, or on reset. They hold between operations and stay stable throughout RUN.
- Arithmetic is modulo 2^WIDTH. Carry out of the MSB is never folded back into S.

## Timing
- **Reset values:** S=0, C=0, V=0, Z=0, N=0, BUSY=0, DONE=0, state IDLE. All internal registers are also 0.
- **Edge numbering:** e0 is the edge that accepts START. BUSY rises after e0. The results update at eK. DONE is high in the cycle between eK and eK+1. BUSY falls after eK+1.
- **Throughput:** one operation per K+2 cycles. The earliest next START is sampled at eK+2.
- **Reset mid-operation:** RST_N low asynchronously forces all reset values immediately. The operation is abandoned and no DONE is produced.
- **Degenerate width:** with CHUNK == WIDTH (K=1), the block still passes through RUN for one edge and then DONE.

## Structure
- **Package add_sub_seq_pkg holds:**
  - the state enum (IDLE, RUN, DONE);
  - the mode constants MODE_ADD=0 and MODE_SUB=1;
  - a function computing K and the counter width, $clog2(K) with a minimum of 1.
- **Sub-module chunk_adder:**
  - Parameter CHUNK; inputs x[CHUNK], y[CHUNK] and cin.
  - Outputs sum[CHUNK], cout and c_msb_in, the carry into its top bit.
  - Built as a ripple of full adders.
  - add_sub_seq instantiates exactly one.

## Test plan
All scenarios use WIDTH=8, CHUNK=2, so K=4.
- **Reset:** hold RST_N low, then release → S=0x00, C=V=Z=N=0, BUSY=0, DONE=0.
- **Add:** START, M=0, A=0x5A, B=0x3C →
  - DONE pulses in the cycle after e4;
  - S=0x96, C=0, V=1, N=1, Z=0;
  - BUSY high from e0 through e5;
  - S stays at its old value during RUN.
- **Subtract, zero result:** M=1, A=0x10, B=0x10 → S=0x00, C=1, V=0, Z=1, N=0.
- **Subtract, overflow:** M=1, A=0x80, B=0x01 → S=0x7F, C=1, V=1, N=0.
- **Accumulate:**
  - CLR pulse, then three ops with ACC=1, M=0, B=0xFF.
  - Expected S sequence 0xFF (C=0), 0xFE (C=1), 0xFD (C=1).
  - A is driven with 0xAA throughout to prove it is ignored.
  - CLR+START together in IDLE → S=0, no operation starts.
- **Busy and reset:**
  - START with A=0x01, B=0x01, then re-pulse START with different operands at e2 → ignored; the result is still 0x02.
  - Start a new op and drive RST_N low at e2 → outputs return to 0 immediately and no DONE appears.
